// File: rtl/io_debouncer.sv
// -----------------------------------------------------------------------------
// io_debouncer
//
// Input conditioning between raw switch/button pins and the datapath io_in
// port. Each bit is handled independently:
//   1. a two-flop synchronizer brings the asynchronous pin into the clk domain,
//   2. a stability counter filters contact bounce,
//   3. the filtered level is presented on io_stable.
// With IO_DEBOUNCE_EDGE_EN defined, a registered one-cycle rising-edge pulse
// per bit is also produced on io_rise.
//
// Parameters:
//   WIDTH            number of independent input bits
//   DEBOUNCE_CYCLES  consecutive cycles a synchronized value must differ from
//                    the stable value before it is accepted (2..65535)
//
// Ports:
//   clk        in   1      divided system clock, rising-edge active
//   rst        in   1      asynchronous reset, active low
//   io_raw     in   WIDTH  raw, asynchronous, bouncing pin levels
//   io_stable  out  WIDTH  debounced level, registered
//   io_rise    out  WIDTH  one-cycle 0->1 pulse per bit, registered
//                          (only when IO_DEBOUNCE_EDGE_EN is defined)
//
// Build option: IO_DEBOUNCE_EDGE_EN
// -----------------------------------------------------------------------------
module io_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] io_raw,
`ifdef IO_DEBOUNCE_EDGE_EN
  output logic [WIDTH-1:0] io_stable,
  output logic [WIDTH-1:0] io_rise
`else
  output logic [WIDTH-1:0] io_stable
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Synchronizer stages: pure flop-to-flop, nothing in between.
  logic [WIDTH-1:0] s1_d, s1_q;
  logic [WIDTH-1:0] s2_d, s2_q;

  // Accepted stable level and per-bit stability counters.
  logic [WIDTH-1:0]            st_d, st_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    s1_d = io_raw;
    s2_d = s1_q;
  end

  // Per-bit filter. Any return to the stable value clears the counter, so
  // progress is never carried across a glitch; acceptance also clears it,
  // which keeps the count bounded at DEBOUNCE_CYCLES-1.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    st_d  = st_q;
    cnt_d = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] == st_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        st_d[i]  = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      st_q  <= '0;
      // NOTE: the counters are reset too; a count left over from before reset
      // would let a post-reset change be accepted early.
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  assign io_stable = st_q;

`ifdef IO_DEBOUNCE_EDGE_EN
  // Pulse in the same cycle io_stable first reads 1; falling edges are ignored.
  logic [WIDTH-1:0] rise_d, rise_q;

  always_comb begin
    rise_d = st_d & ~st_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_q <= '0;
    end else begin
      rise_q <= rise_d;
    end
  end

  assign io_rise = rise_q;
`endif

endmodule

// File: tb/tb_io_debouncer.sv
// -----------------------------------------------------------------------------
// tb_io_debouncer
//
// Randomized and directed stimulus for io_debouncer. A reference model turns
// each clock edge into an expected {io_stable, io_rise} pair and queues it; a
// monitor on the falling edge pops and compares against the DUT outputs.
//
// Model rule: the value compared at a given edge is the raw pin level sampled
// two edges earlier. A bit of the stable level flips when the last
// DEBOUNCE_CYCLES such compared values all differ from the current level.
// -----------------------------------------------------------------------------
module tb_io_debouncer;

  localparam int W = 4;
  localparam int D = 16;

  logic         clk;
  logic         rst;
  logic [W-1:0] io_raw;
  logic [W-1:0] io_stable;
`ifdef IO_DEBOUNCE_EDGE_EN
  logic [W-1:0] io_rise;
`endif

  io_debouncer #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .io_raw   (io_raw),
`ifdef IO_DEBOUNCE_EDGE_EN
    .io_stable(io_stable),
    .io_rise  (io_rise)
`else
    .io_stable(io_stable)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard queue
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [W-1:0] stable;
    logic [W-1:0] rise;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] raw_hist[$];   // raw levels sampled at recent edges
  logic [W-1:0] seen_hist[$];  // values compared against the stable level
  logic [W-1:0] m_st;

  initial begin
    logic [W-1:0] seen;
    logic [W-1:0] nxt;
    logic         all_diff;
    m_st = '0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        raw_hist.delete();
        seen_hist.delete();
        exp_q.delete();
        m_st = '0;
      end else begin
        seen = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : '0;
        raw_hist.push_back(io_raw);
        if (raw_hist.size() > 2) void'(raw_hist.pop_front());
        seen_hist.push_back(seen);
        if (seen_hist.size() > D) void'(seen_hist.pop_front());
        nxt = m_st;
        if (seen_hist.size() == D) begin
          for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            foreach (seen_hist[j]) begin
              if (seen_hist[j][b] == m_st[b]) all_diff = 1'b0;
            end
            if (all_diff) nxt[b] = ~m_st[b];
          end
        end
        exp_q.push_back('{stable: nxt, rise: nxt & ~m_st});
        m_st = nxt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compares on the falling edge, away from the active edge
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("stable_in_reset", io_stable, '0);
`ifdef IO_DEBOUNCE_EDGE_EN
        check("rise_in_reset", io_rise, '0);
`endif
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stable", io_stable, e.stable);
`ifdef IO_DEBOUNCE_EDGE_EN
        check("rise", io_rise, e.rise);
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus (inputs change just after the falling edge)
  // ---------------------------------------------------------------------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pull reset low between clock edges and confirm outputs clear at once.
  task automatic async_reset(input string name);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check(name, io_stable, '0);
`ifdef IO_DEBOUNCE_EDGE_EN
    check({name, "_rise"}, io_rise, '0);
`endif
    cycles(2);
    rst = 1'b1;
  endtask

  initial begin
    rst    = 1'b0;
    io_raw = 4'hF;

    // Reset held with all pins high, then released: all bits accepted once.
    cycles(5);
    rst = 1'b1;
    cycles(25);

    // All pins released.
    io_raw = 4'h0;
    cycles(22);

    // Clean press on bit 0.
    io_raw[0] = 1'b1;
    cycles(22);

    // Bounce on bit 1: alternating 5-cycle phases, then settle high.
    for (int c = 0; c < 40; c++) begin
      io_raw[1] = ((c / 5) % 2 == 0);
      cycles(1);
    end
    io_raw[1] = 1'b1;
    cycles(22);

    // Release bit 0; bit 1 back low to return to a known state.
    io_raw[0] = 1'b0;
    io_raw[1] = 1'b0;
    cycles(22);

    // Reset in the middle of a count on bit 2.
    io_raw[2] = 1'b1;
    cycles(10);
    async_reset("stable_after_async_reset");
    cycles(22);

    // Short pulses just under and exactly at the acceptance width on bit 3.
    io_raw[3] = 1'b1;
    cycles(D - 1);
    io_raw[3] = 1'b0;
    cycles(22);
    io_raw[3] = 1'b1;
    cycles(D);
    io_raw[3] = 1'b0;
    cycles(22);

    // Random toggling; average run length near the acceptance window.
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(0, 15) == 0) io_raw[b] = ~io_raw[b];
      end
      if (c == 150 || c == 300) async_reset("stable_random_reset");
      else cycles(1);
    end

    cycles(25);
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_debouncer.md
# io_debouncer

Input conditioning stage between the board's raw switch/button pins and the datapath's `io_in` port. Per bit: synchronizes the asynchronous pin into the divided clock domain, filters contact bounce with a stability counter, and presents a clean level. Optionally emits a one-cycle rising-edge pulse per bit. Instantiated in the top level on the divided clock; `io_stable` drives the datapath's `io_in`.

## Interface
- `WIDTH`, 4: number of independent input bits.
- `DEBOUNCE_CYCLES`, 16: consecutive cycles a synchronized value must differ from the current stable value before it is accepted; legal range 2..65535; counter width is `$clog2(DEBOUNCE_CYCLES)`.

- `clk`  input  1  divided system clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-low reset (asserted when 0).
- `io_raw`  input  WIDTH  raw, asynchronous, bouncing pin levels.
- `io_stable`  output  WIDTH  debounced level, registered.
- `io_rise`  output  WIDTH  one-cycle pulse when the corresponding `io_stable` bit goes 0→1, registered; present only with `IO_DEBOUNCE_EDGE_EN`.

## Operation
- Per bit `i`, fully independent; no shared state between bits.
- Synchronizer: two flops, `s1[i] <= io_raw[i]`, `s2[i] <= s1[i]`. No logic between them.
- Counter `cnt[i]`, stable register `st[i]` (drives `io_stable[i]`).
- Each rising edge:
  - `s2[i] == st[i]`: `cnt[i] <= 0`.
  - `s2[i] != st[i]` and `cnt[i] == DEBOUNCE_CYCLES-1`: `st[i] <= s2[i]`, `cnt[i] <= 0`.
  - `s2[i] != st[i]` otherwise: `cnt[i] <= cnt[i] + 1`.
- A difference that disappears before acceptance resets the counter; progress is never retained across glitches.
- Counter never exceeds `DEBOUNCE_CYCLES-1`; no wrap-around.
- Edge output: `io_rise[i] <= (next st[i] == 1) && (st[i] == 0)`, i.e. high in exactly the cycle in which `io_stable[i]` first reads 1, low otherwise. Falling transitions produce no pulse.
- Reset (`rst == 0`, asynchronous, at any time including mid-count): `s1`, `s2`, `st`, `cnt`, `io_rise` all 0. After release, a pin held at 1 is treated as a fresh 0→1 transition and produces one `io_rise` pulse.

## Timing
- Reset values: `io_stable = 0`, `io_rise = 0`.
- Latency: a raw change sampled by `s1` at edge k, held steady, appears on `io_stable` after edge k+1+`DEBOUNCE_CYCLES`. With the default of 16, this is the 18th rising edge, counting edge k as the 1st.
- `io_rise` asserts on the same edge as `io_stable` and lasts exactly one cycle.
- Rejection: any raw pulse shorter than `DEBOUNCE_CYCLES` cycles (as seen at `s2`) never reaches `io_stable`.
- Minimum accepted pulse width is `DEBOUNCE_CYCLES` cycles, for both the high and the low phase.
- Simultaneous changes on several bits are processed in parallel; each bit meets the latency above independently.

## Configuration
- `IO_DEBOUNCE_EDGE_EN` defined: the `io_rise` port and its register exist with the behaviour above.
- Not defined: the `io_rise` port is absent from the module and no edge-detect logic is generated. `io_stable` behaviour is identical in both builds.

## Test plan
- Reset: hold `rst=0` with `io_raw=4'hF` → `io_stable=0` and `io_rise=0` throughout. Release → `io_stable=4'hF` after edge 18; `io_rise=4'hF` for exactly that one cycle.
- Clean press: `io_raw[0]` 0→1 and held (default parameters) → `io_stable=4'b0001` after the 18th edge, not before; with the edge feature built in, `io_rise=4'b0001` for one cycle.
- Bounce rejection: `io_raw[1]` toggles 1,0 with periods of 5 cycles for 40 cycles, then settles at 1 → `io_stable[1]` stays 0 during the toggling and becomes 1 exactly 18 edges after the final settle.
- Release: `io_stable=4'b0001`, `io_raw[0]` 1→0 and held → `io_stable=0` after 18 edges; `io_rise` stays 0.
- Reset mid-count: `io_raw[2]=1` held for 10 cycles, then `rst` pulsed low asynchronously between clock edges → all outputs 0 immediately. The count restarts after release, and `io_stable[2]=1` 18 edges after release.
- Build without `IO_DEBOUNCE_EDGE_EN`: the press and bounce scenarios above repeated → identical `io_stable` waveforms; the port list contains no `io_rise`.
